seg_scan_driver: RTL and testbench



---
 rtl/seg_scan_driver.sv | 169 ++++++++++++++++
 tb/tb_seg_scan_driver.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - four-digit seven-segment scan driver with frame-synchronous load
module seg_scan_driver #(
    parameter int SCAN_DIV     = 100000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        ld,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_mask,
    input  logic [3:0]  blink_mask,
    input  logic        lz_en,
    output logic [7:0]  led,
    output logic [3:0]  ena,
    output logic        frame_done
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic [CW-1:0] scan_cnt;
    logic [FW-1:0] frame_cnt;
    logic [1:0]    idx;
    logic          blink_phase;

    logic [15:0]   sh_digits;
    logic [3:0]    sh_dp;
    logic [3:0]    sh_blink;
    logic          sh_lz;

    logic [15:0]   pd_digits;
    logic [3:0]    pd_dp;
    logic [3:0]    pd_blink;
    logic          pd_lz;
    logic          pend;

    logic          terminal;
    logic          wrap;
    logic [3:0]    code [4];
    logic [3:0]    lead_zero;
    logic [3:0]    cur_code;
    logic          suppress;
    logic [7:0]    seg_next;

    function automatic logic [7:0] seg_map(input logic [3:0] c);
        logic [7:0] s;
        case (c)
            4'h0:    s = 8'hFC;
            4'h1:    s = 8'h60;
            4'h2:    s = 8'hDA;
            4'h3:    s = 8'hF2;
            4'h4:    s = 8'h66;
            4'h5:    s = 8'hB6;
            4'h6:    s = 8'hBE;
            4'h7:    s = 8'hE0;
            4'h8:    s = 8'hFE;
            4'h9:    s = 8'hF6;
            4'hA:    s = 8'h02;
            4'hB:    s = 8'h00;
            4'hC:    s = 8'h9C;
            4'hD:    s = 8'h7A;
            4'hE:    s = 8'h9E;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    assign terminal = (scan_cnt == SCAN_LAST);
    assign wrap     = terminal && (idx == 2'd0);

    // lead_zero[i]: digit i and every digit to its left hold code 0
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            code[i] = sh_digits[i*4 +: 4];
        end
        lead_zero    = 4'b0000;
        lead_zero[3] = (code[3] == 4'h0);
        for (int i = 2; i >= 0; i--) begin
            lead_zero[i] = lead_zero[i+1] && (code[i] == 4'h0);
        end
    end

    always_comb begin
        cur_code = code[idx];
        suppress = sh_lz && (idx != 2'd0) && lead_zero[idx];
        seg_next = 8'h00;
        if (!(blink_phase && sh_blink[idx])) begin
            seg_next = (suppress ? 8'h00 : seg_map(cur_code)) | {7'b0, sh_dp[idx]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led         <= 8'h00;
            ena         <= 4'b0000;
            frame_done  <= 1'b0;
            idx         <= 2'd3;
            scan_cnt    <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            sh_digits   <= 16'hBBBB;
            sh_dp       <= 4'b0000;
            sh_blink    <= 4'b0000;
            sh_lz       <= 1'b0;
            pd_digits   <= 16'hBBBB;
            pd_dp       <= 4'b0000;
            pd_blink    <= 4'b0000;
            pd_lz       <= 1'b0;
            pend        <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (!en) begin
                led         <= 8'h00;
                ena         <= 4'b0000;
                idx         <= 2'd3;
                scan_cnt    <= '0;
                frame_cnt   <= '0;
                blink_phase <= 1'b0;
                // Dark display cannot tear, so loads bypass the pending stage
                if (ld) begin
                    sh_digits <= digits;
                    sh_dp     <= dp_mask;
                    sh_blink  <= blink_mask;
                    sh_lz     <= lz_en;
                end
            end else begin
                led <= seg_next;
                ena <= 4'b0001 << idx;
                if (terminal) begin
                    scan_cnt <= '0;
                    idx      <= idx - 2'd1;
                end else begin
                    scan_cnt <= scan_cnt + 1'b1;
                end
                if (wrap) begin
                    frame_done <= 1'b1;
                    if (frame_cnt == FRAME_LAST) begin
                        frame_cnt   <= '0;
                        blink_phase <= ~blink_phase;
                    end else begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                    pend <= 1'b0;
                    if (ld) begin
                        sh_digits <= digits;
                        sh_dp     <= dp_mask;
                        sh_blink  <= blink_mask;
                        sh_lz     <= lz_en;
                    end else if (pend) begin
                        sh_digits <= pd_digits;
                        sh_dp     <= pd_dp;
                        sh_blink  <= pd_blink;
                        sh_lz     <= pd_lz;
                    end
                end else if (ld) begin
                    pd_digits <= digits;
                    pd_dp     <= dp_mask;
                    pd_blink  <= blink_mask;
                    pd_lz     <= lz_en;
                    pend      <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - scoreboard bench for seg_scan_driver
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        ld;
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    logic [3:0]  blink_mask;
    logic        lz_en;
    logic [7:0]  led;
    logic [3:0]  ena;
    logic        frame_done;

    typedef struct packed {
        logic [3:0] ena;
        logic [7:0] led;
    } exp_t;

    exp_t       sb_q [$];
    int         checks   = 0;
    int         errors   = 0;
    int         fd_count = 0;
    logic [3:0] prev_ena = 4'b0000;
    logic       prev_fd  = 1'b0;

    seg_scan_driver #(
        .SCAN_DIV     (4),
        .BLINK_FRAMES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .ld         (ld),
        .digits     (digits),
        .dp_mask    (dp_mask),
        .blink_mask (blink_mask),
        .lz_en      (lz_en),
        .led        (led),
        .ena        (ena),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_dig(input logic [3:0] e, input logic [7:0] l);
        exp_t x;
        x.ena = e;
        x.led = l;
        sb_q.push_back(x);
    endtask

    task automatic push_frame(input logic [7:0] l3, input logic [7:0] l2,
                              input logic [7:0] l1, input logic [7:0] l0);
        push_dig(4'b1000, l3);
        push_dig(4'b0100, l2);
        push_dig(4'b0010, l1);
        push_dig(4'b0001, l0);
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] dp,
                        input logic [3:0] bl, input logic lz);
        digits     = d;
        dp_mask    = dp;
        blink_mask = bl;
        lz_en      = lz;
        ld         = 1'b1;
    endtask

    // Monitor: each new digit presentation pops one expected entry
    always @(negedge clk) begin
        if (rst) begin
            if (frame_done) begin
                fd_count++;
                check("frame_done_on_digit0", ena, 4'b0001);
                check("frame_done_one_cycle", prev_fd, 1'b0);
            end
            if (ena != 4'b0000 && ena != prev_ena) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_digit", ena, 4'b0000);
                end else begin
                    exp_t x;
                    x = sb_q.pop_front();
                    check("sb_ena", ena, x.ena);
                    check("sb_led", led, x.led);
                end
            end
        end
        prev_ena = ena;
        prev_fd  = frame_done;
    end

    initial begin
        logic [3:0] exp_ena;
        rst        = 1'b0;
        en         = 1'b0;
        ld         = 1'b0;
        digits     = 16'h0000;
        dp_mask    = 4'b0000;
        blink_mask = 4'b0000;
        lz_en      = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_led", led, 8'h00);
        check("reset_ena", ena, 4'b0000);
        check("reset_frame_done", frame_done, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        load(16'h1234, 4'b0000, 4'b0000, 1'b0);
        @(negedge clk);
        ld = 1'b0;
        push_frame(8'h60, 8'hDA, 8'hF2, 8'h66);
        en = 1'b1;

        for (int c = 1; c <= 207; c++) begin
            @(negedge clk);
            ld = 1'b0;
            if (c <= 16) begin
                exp_ena = 4'b1000 >> ((c - 1) / 4);
                check("scan_ena_f1", ena, exp_ena);
                check("frame_done_f1", frame_done, (c == 16) ? 1'b1 : 1'b0);
            end
            case (c)
                8: begin
                    load(16'h0070, 4'b0000, 4'b0000, 1'b1);
                    push_frame(8'h00, 8'h00, 8'hE0, 8'hFC);
                end
                20: begin
                    load(16'h0070, 4'b0000, 4'b0000, 1'b0);
                    push_frame(8'hFC, 8'hFC, 8'hE0, 8'hFC);
                end
                37: begin
                    load(16'h8888, 4'b0000, 4'b0000, 1'b0);
                    push_frame(8'hFE, 8'hFE, 8'hFE, 8'hFE);
                end
                50: load(16'h9999, 4'b1111, 4'b0000, 1'b0);
                55: begin
                    load(16'h1235, 4'b0001, 4'b0001, 1'b0);
                    push_frame(8'h60, 8'hDA, 8'hF2, 8'hB7);
                    push_frame(8'h60, 8'hDA, 8'hF2, 8'hB7);
                    push_frame(8'h60, 8'hDA, 8'hF2, 8'h00);
                    push_frame(8'h60, 8'hDA, 8'hF2, 8'h00);
                    push_frame(8'h60, 8'hDA, 8'hF2, 8'hB7);
                    push_frame(8'h60, 8'hDA, 8'hF2, 8'hB7);
                    push_dig(4'b1000, 8'h60);
                    push_dig(4'b0100, 8'hDA);
                    push_dig(4'b0010, 8'hF2);
                end
                165: begin
                    load(16'hABCE, 4'b0000, 4'b0000, 1'b0);
                    push_frame(8'h60, 8'hDA, 8'hF2, 8'hB7);
                    push_frame(8'h02, 8'h00, 8'h9C, 8'h9E);
                    push_dig(4'b1000, 8'h02);
                end
                169: en = 1'b0;
                170: begin
                    check("dis_led", led, 8'h00);
                    check("dis_ena", ena, 4'b0000);
                    check("dis_frame_done", frame_done, 1'b0);
                end
                172: begin
                    check("dis_hold_ena", ena, 4'b0000);
                    en = 1'b1;
                end
                173: begin
                    check("reen_ena", ena, 4'b1000);
                    check("reen_led", led, 8'h60);
                end
                176: check("reen_hold_ena", ena, 4'b1000);
                177: begin
                    check("reen_step_ena", ena, 4'b0100);
                    check("reen_step_led", led, 8'hDA);
                end
                207: begin
                    #2;
                    rst = 1'b0;
                    #1;
                    check("async_rst_led", led, 8'h00);
                    check("async_rst_ena", ena, 4'b0000);
                    check("async_rst_frame_done", frame_done, 1'b0);
                end
                default: ;
            endcase
        end

        repeat (3) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);
        check("frame_done_count", fd_count, 12);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
